// File: rtl/dsp_data_mem_pkg.sv
// Shared definitions for the DSP data-memory responder: default word/address
// widths and the host read FSM state encoding.
package dsp_data_mem_pkg;

  localparam int REG_WORD_LEN  = 16;
  localparam int SRAM_ADDR_LEN = 8;

  typedef enum logic [1:0] {
    DMEM_H_IDLE = 2'd0,
    DMEM_H_READ = 2'd1,
    DMEM_H_ACK  = 2'd2
  } dmem_h_state_e;

endpackage

// File: rtl/dsp_data_mem_if.sv
// Sample-stream and host-readback bus of the DSP data memory.
// master = front-end/host side, slave = dsp_data_mem.
interface dsp_data_mem_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              freeze;
  logic              frame_done;
  logic              h_req;
  logic [ADDR_W-1:0] h_addr;
  logic              h_ack;
  logic [DATA_W-1:0] h_data;

  modport master (
    output s_valid, s_data, freeze, h_req, h_addr,
    input  s_ready, frame_done, h_ack, h_data
  );

  modport slave (
    input  s_valid, s_data, freeze, h_req, h_addr,
    output s_ready, frame_done, h_ack, h_data
  );

endinterface

// File: rtl/dsp_data_mem_bank.sv
// dmem_bank: 2^ADDR_W x DATA_W array with one write port and one registered
// read port. BYPASS selects write-first forwarding on an address match;
// otherwise the read returns the pre-write contents. The array itself is not
// reset; only the read register is.
module dmem_bank #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter bit BYPASS = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Array write port
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read data selection: hold unless enabled, optional same-cycle forwarding
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = mem_q[raddr_i];
      if (BYPASS && we_i && (waddr_i == raddr_i)) rdata_d = wdata_i;
    end
  end

  // Registered read port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dsp_data_mem.sv
// DSP data memory responder. Bank I: sample buffer filled from the s_* stream,
// read-only to the DSP. Bank II: DSP read/write scratch, read back by the
// host through a 4-phase req/ack handshake. Bank II is two parallel copies
// so the DSP read port and the host read port never contend.
// Optional build macro: DMEM_WRITE_BYPASS_EN (write-first Bank II reads).
module dsp_data_mem
  import dsp_data_mem_pkg::*;
#(
  parameter int DATA_W = REG_WORD_LEN,
  parameter int ADDR_W = SRAM_ADDR_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] read_addr_1,
  output logic [DATA_W-1:0] read_data_1,
  input  logic [ADDR_W-1:0] read_addr_2,
  output logic [DATA_W-1:0] read_data_2,
  input  logic [ADDR_W-1:0] write_addr_2,
  input  logic [DATA_W-1:0] write_data_2,
  input  logic              write_en_2,
  dsp_data_mem_if.slave     bus
);

`ifdef DMEM_WRITE_BYPASS_EN
  localparam bit BANK2_BYPASS = 1'b1;
`else
  localparam bit BANK2_BYPASS = 1'b0;
`endif

  logic              ingest_we;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic              frame_done_q, frame_done_d;
  dmem_h_state_e     state_q, state_d;
  logic              h_rd_en;
  logic              h_ack;

  // Freeze blocks ingest outright; a sample offered while frozen is not taken
  assign bus.s_ready = !bus.freeze;
  assign ingest_we   = bus.s_valid && !bus.freeze;

  // Ingest pointer advance and end-of-frame detection
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    frame_done_d = 1'b0;
    if (ingest_we) begin
      wr_ptr_d     = wr_ptr_q + 1'b1;
      frame_done_d = (wr_ptr_q == {ADDR_W{1'b1}});
    end
  end

  // Ingest control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.frame_done = frame_done_q;

  // Host FSM next state; the DSP write owns the shared port, host waits
  always_comb begin
    state_d = state_q;
    h_rd_en = 1'b0;
    h_ack   = 1'b0;
    unique case (state_q)
      DMEM_H_IDLE: if (bus.h_req && !write_en_2) state_d = DMEM_H_READ;
      DMEM_H_READ: begin
        h_rd_en = 1'b1;
        state_d = DMEM_H_ACK;
      end
      DMEM_H_ACK: begin
        h_ack = 1'b1;
        if (!bus.h_req) state_d = DMEM_H_IDLE;
      end
      default: state_d = DMEM_H_IDLE;
    endcase
  end

  // Host FSM state register; reset aborts any handshake in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= DMEM_H_IDLE;
    else      state_q <= state_d;
  end

  assign bus.h_ack = h_ack;

  // Bank I never forwards: a read colliding with ingest sees the old word
  dmem_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(1'b0)) u_bank1 (
    .clk     (clk),
    .rst_n   (rst),
    .we_i    (ingest_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.s_data),
    .re_i    (1'b1),
    .raddr_i (read_addr_1),
    .rdata_o (read_data_1)
  );

  dmem_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BANK2_BYPASS)) u_bank2_dsp (
    .clk     (clk),
    .rst_n   (rst),
    .we_i    (write_en_2),
    .waddr_i (write_addr_2),
    .wdata_i (write_data_2),
    .re_i    (1'b1),
    .raddr_i (read_addr_2),
    .rdata_o (read_data_2)
  );

  // Host copy only reads in READ, so h_data holds through ACK
  dmem_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BANK2_BYPASS)) u_bank2_host (
    .clk     (clk),
    .rst_n   (rst),
    .we_i    (write_en_2),
    .waddr_i (write_addr_2),
    .wdata_i (write_data_2),
    .re_i    (h_rd_en),
    .raddr_i (bus.h_addr),
    .rdata_o (bus.h_data)
  );

endmodule

// File: tb/tb_dsp_data_mem.sv
// Directed bench for dsp_data_mem with ADDR_W=4, DATA_W=16.
// Expected values are hand-computed; bypass-dependent ones follow
// DMEM_WRITE_BYPASS_EN.
module tb_dsp_data_mem;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

`ifdef DMEM_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] read_addr_1;
  logic [DATA_W-1:0] read_data_1;
  logic [ADDR_W-1:0] read_addr_2;
  logic [DATA_W-1:0] read_data_2;
  logic [ADDR_W-1:0] write_addr_2;
  logic [DATA_W-1:0] write_data_2;
  logic              write_en_2;

  int n_cmp = 0;
  int n_err = 0;

  dsp_data_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dsp_data_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .read_addr_1  (read_addr_1),
    .read_data_1  (read_data_1),
    .read_addr_2  (read_addr_2),
    .read_data_2  (read_data_2),
    .write_addr_2 (write_addr_2),
    .write_data_2 (write_data_2),
    .write_en_2   (write_en_2),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b0;
    read_addr_1  = '0;
    read_addr_2  = '0;
    write_addr_2 = '0;
    write_data_2 = '0;
    write_en_2   = 1'b0;
    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.freeze   = 1'b0;
    bus.h_req    = 1'b0;
    bus.h_addr   = '0;

    // Reset state
    repeat (3) step();
    check_val("rst_rd1", read_data_1, 0);
    check_val("rst_rd2", read_data_2, 0);
    check_val("rst_hdata", bus.h_data, 0);
    check_val("rst_hack", bus.h_ack, 0);
    check_val("rst_fdone", bus.frame_done, 0);
    check_val("rst_sready", bus.s_ready, 1);
    rst = 1'b1;
    #1;
    check_val("rel_rd1", read_data_1, 0);
    check_val("rel_hack", bus.h_ack, 0);
    check_val("rel_sready", bus.s_ready, 1);
    step();

    // Ingest 17 samples: frame_done only after the write to address 15
    for (int i = 0; i < 17; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = 16'h0100 + 16'(i);
      step();
      check_val($sformatf("fdone_%0d", i), bus.frame_done, (i == 15) ? 1 : 0);
    end
    bus.s_valid = 1'b0;
    read_addr_1 = 4'd0;
    step();
    check_val("wrap_addr0", read_data_1, 16'h0110);
    check_val("fdone_after", bus.frame_done, 0);
    read_addr_1 = 4'd1;
    step();
    check_val("wrap_addr1", read_data_1, 16'h0101);

    // Ingest write and read of the same address: old word returned
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h02AA;
    step();
    check_val("coll_old", read_data_1, 16'h0101);
    bus.s_valid = 1'b0;
    step();
    check_val("coll_new", read_data_1, 16'h02AA);

    // Freeze: no write, pointer stays at 2
    bus.freeze  = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h03CC;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val($sformatf("frz_sready_%0d", i), bus.s_ready, 0);
      step();
    end
    bus.freeze  = 1'b0;
    bus.s_valid = 1'b0;
    read_addr_1 = 4'd2;
    #1;
    check_val("unfrz_sready", bus.s_ready, 1);
    step();
    check_val("frz_nowrite", read_data_1, 16'h0102);
    bus.s_valid = 1'b1;
    bus.s_data  = 16'h04DD;
    step();
    bus.s_valid = 1'b0;
    step();
    check_val("frz_ptr", read_data_1, 16'h04DD);

    // DSP Bank II write then read, and same-cycle read-during-write
    write_en_2   = 1'b1;
    write_addr_2 = 4'd5;
    write_data_2 = 16'h1111;
    step();
    write_data_2 = 16'hBEEF;
    read_addr_2  = 4'd5;
    step();
    check_val("rdw_same", read_data_2, BYP ? 16'hBEEF : 16'h1111);
    write_en_2 = 1'b0;
    step();
    check_val("wr_rd", read_data_2, 16'hBEEF);

    // Host handshake, no conflict: ack 2 cycles after request
    bus.h_req  = 1'b1;
    bus.h_addr = 4'd5;
    step();
    check_val("h_ack_c1", bus.h_ack, 0);
    step();
    check_val("h_ack_c2", bus.h_ack, 1);
    check_val("h_data", bus.h_data, 16'hBEEF);
    step();
    check_val("h_ack_hold", bus.h_ack, 1);
    bus.h_req = 1'b0;
    step();
    check_val("h_ack_drop", bus.h_ack, 0);

    // Host request with two cycles of DSP write: ack after 4 cycles
    bus.h_req    = 1'b1;
    bus.h_addr   = 4'd5;
    write_en_2   = 1'b1;
    write_addr_2 = 4'd6;
    write_data_2 = 16'h0C0C;
    step();
    check_val("cf_c1", bus.h_ack, 0);
    write_addr_2 = 4'd7;
    write_data_2 = 16'h0707;
    step();
    check_val("cf_c2", bus.h_ack, 0);
    write_en_2 = 1'b0;
    step();
    check_val("cf_c3", bus.h_ack, 0);
    step();
    check_val("cf_c4", bus.h_ack, 1);
    check_val("cf_data", bus.h_data, 16'hBEEF);
    bus.h_req = 1'b0;
    step();
    check_val("cf_drop", bus.h_ack, 0);

    // Host read coinciding with a DSP write to the same address
    bus.h_req  = 1'b1;
    bus.h_addr = 4'd6;
    step();
    write_en_2   = 1'b1;
    write_addr_2 = 4'd6;
    write_data_2 = 16'h6666;
    step();
    write_en_2 = 1'b0;
    check_val("hfwd_ack", bus.h_ack, 1);
    check_val("hfwd_data", bus.h_data, BYP ? 16'h6666 : 16'h0C0C);
    bus.h_req = 1'b0;
    step();
    check_val("hfwd_drop", bus.h_ack, 0);

    // Reset while in ACK aborts the handshake immediately
    bus.h_req  = 1'b1;
    bus.h_addr = 4'd7;
    step();
    step();
    check_val("mid_ack", bus.h_ack, 1);
    check_val("mid_data", bus.h_data, 16'h0707);
    rst = 1'b0;
    #1;
    check_val("mid_rst_ack", bus.h_ack, 0);
    check_val("mid_rst_hdata", bus.h_data, 0);
    check_val("mid_rst_rd2", read_data_2, 0);
    bus.h_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    check_val("post_idle", bus.h_ack, 0);
    bus.h_req  = 1'b1;
    bus.h_addr = 4'd7;
    step();
    check_val("post_c1", bus.h_ack, 0);
    step();
    check_val("post_c2", bus.h_ack, 1);
    check_val("post_data", bus.h_data, 16'h0707);
    bus.h_req = 1'b0;
    step();
    check_val("post_drop", bus.h_ack, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
